bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
Multi-client successor to the single-port BRAM path. It shares one internal synchronous block RAM among NUM_PORTS independent request channels using round-robin arbitration. It also provides a hardware zero-fill (init) mode so the planner can clear tree storage between RRT runs without a software loop. It sits between planner-side clients (sampler, nearest-neighbour, tree writer) and node storage.

Parameters:
ADDR_WIDTH, 8, address width per port
DATA_WIDTH, 32, word width
NUM_PORTS, 4, number of client channels (>=1)
DEPTH, 2**ADDR_WIDTH, number of implemented words (<= 2**ADDR_WIDTH)

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  NUM_PORTS  per-port access request; held until granted
we  input  NUM_PORTS  per-port write enable (1=write, 0=read), qualified by req
addr  input  NUM_PORTS*ADDR_WIDTH  flattened per-port addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
w_data  input  NUM_PORTS*DATA_WIDTH  flattened per-port write data; same packing as addr
gnt  output  NUM_PORTS  one-hot-or-zero grant, combinational, same cycle as req
r_valid  output  NUM_PORTS  registered; bit i high for one cycle when r_data holds port i's read result
r_data  output  DATA_WIDTH  registered shared read data
init_start  input  1  single-cycle pulse; starts zero-fill
init_busy  output  1  high while zero-fill is in progress

Behaviour:
- Reset (rst_n low, async): gnt=0, r_valid=0, r_data=0, init_busy=0, state=IDLE, rr_last=NUM_PORTS-1 (port 0 wins first). Memory contents are not cleared by reset.
- States: IDLE and INIT.
- IDLE -> INIT on init_start. INIT -> IDLE after the write to address DEPTH-1.
- IDLE arbitration:
  - Grant the first requesting port scanning rr_last+1, rr_last+2, ... modulo NUM_PORTS.
  - gnt is combinational from req and rr_last. At most one bit is set.
  - On each grant, rr_last <= granted index. Without a grant, rr_last holds.
- Granted write: mem[addr_i] <= w_data_i at that edge. No r_valid.
- Granted read: at the same edge, r_data <= mem[addr_i] and r_valid <= one-hot(i). Latency is 1 cycle from grant.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data. There is no same-cycle read/write, since there is one grant per cycle.
- r_valid is 0 in any cycle after a non-read cycle. r_data holds its last value when r_valid=0.
- Client protocol: the client keeps req/we/addr/w_data stable until it sees gnt. It may deassert req or issue a new request the cycle after gnt.
- INIT:
  - init_busy=1 and gnt=0 throughout.
  - An internal counter walks 0..DEPTH-1, writing 0, one word per cycle. Exactly DEPTH cycles.
  - init_busy falls on the edge that writes DEPTH-1; arbitration resumes that next cycle.
  - init_start during INIT is ignored.
- Simultaneous init_start and req in IDLE: INIT wins. No grant that cycle, and rr_last is unchanged.
- Address >= DEPTH:
  - Write is dropped.
  - Read returns 0 with r_valid still asserted.
  - The grant is still issued and rr_last still updates.
- Reset asserted mid-INIT: return to IDLE with init_busy=0. Memory is partially cleared (contents undefined); a new init_start is required.
- Reset asserted with a read in flight: r_valid=0, and the read is lost.
- NUM_PORTS=1: degenerates to a direct pass-through with gnt=req (when not INIT).

Test Plan:
- Single port: port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> gnt[0] each request cycle; r_valid=4'b0001 and r_data=0xDEADBEEF one cycle after the read grant.
- Contention: ports 0–3 all request reads continuously from reset -> grants in order 0,1,2,3,0,1,…; each port gets exactly 1 of every 4 cycles; r_valid follows gnt by 1 cycle.
- Fairness skip: only ports 1 and 3 requesting, rr_last=1 -> next grants 3,1,3; no grant to idle ports.
- Init: fill addr 0..255 with nonzero values, pulse init_start with req=4'b1111 on the same cycle:
  - init_busy high exactly 256 cycles; gnt=0 throughout.
  - Afterwards, reads of addr 0, 128 and 255 return 0.
- Reset mid-init: pulse rst_n low at INIT cycle 100 -> init_busy=0 immediately; gnt resumes after release; addr 0 reads 0 and addr 200 keeps its old value.
- Out of range: DEPTH=200; write 0x1234 to addr 210, then read it -> r_valid asserted with r_data=0; addr 199 is unaffected.

Source files
------------

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin multi-port arbiter in front of one shared block RAM
// Also hosts a hardware zero-fill walk used to clear node storage between planner runs.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  w_data,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             r_valid,
  output logic [DATA_WIDTH-1:0]            r_data,
  input  logic                             init_start,
  output logic                             init_busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_INIT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [PW-1:0]           rr_last_q;
  logic [NUM_PORTS-1:0]    r_valid_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    arb_en;
  logic                    gnt_any;
  logic [PW-1:0]           gnt_idx;
  logic [NUM_PORTS-1:0]    gnt_vec;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_we;
  logic                    sel_in_range;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    case (state_q)
      S_IDLE: if (init_start) state_d = S_INIT;
      S_INIT: begin
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_IDLE;
        else init_cnt_d = init_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A starting init pre-empts any request presented in the same cycle.
  always_comb begin
    init_busy = (state_q == S_INIT);
    arb_en    = (state_q == S_IDLE) && !init_start && rst_n;
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_last_q) + k) % NUM_PORTS;
      if (!gnt_any && arb_en && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    gnt_vec = '0;
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  assign gnt          = gnt_vec;
  assign sel_addr     = addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata    = w_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_we       = we[gnt_idx];
  assign sel_in_range = int'(sel_addr) < DEPTH;

  assign mem_we    = init_busy || (gnt_any && sel_we && sel_in_range);
  assign mem_waddr = init_busy ? init_cnt_q : sel_addr;
  assign mem_wdata = init_busy ? '0 : sel_wdata;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
      rr_last_q  <= PW'(NUM_PORTS - 1);
      r_valid_q  <= '0;
      r_data_q   <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
      r_valid_q  <= gnt_vec & ~we;
      if (gnt_any) rr_last_q <= gnt_idx;
      if (gnt_any && !sel_we) r_data_q <= sel_in_range ? mem[sel_addr] : '0;
    end
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - randomized and directed bench for bram_arbiter against a behavioural model
module tb_bram_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req, we, gnt, r_valid;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] w_data;
  logic [DW-1:0]    r_data;
  logic             init_start, init_busy;

  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .w_data(w_data),
    .gnt(gnt), .r_valid(r_valid), .r_data(r_data),
    .init_start(init_start), .init_busy(init_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Client side: each port holds its request until granted.
  bit            pend [NP];
  bit            c_we [NP];
  logic [AW-1:0] c_addr [NP];
  logic [DW-1:0] c_data [NP];

  // Reference model state.
  logic [DW-1:0] mm [256];
  int            m_rr, m_cnt;
  bit            m_busy;
  logic [NP-1:0] m_rv;
  logic [DW-1:0] m_rd;
  int            busy_seen;
  int            gcount [NP];
  logic [NP-1:0] obs_gnt;

  task automatic model_reset();
    m_rr = NP - 1; m_busy = 0; m_cnt = 0; m_rv = '0; m_rd = '0;
    for (int i = 0; i < NP; i++) pend[i] = 0;
  endtask

  task automatic post(input int p, input bit w, input int a, input logic [31:0] d);
    pend[p] = 1; c_we[p] = w; c_addr[p] = AW'(a); c_data[p] = d;
  endtask

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < NP; i++) r |= pend[i];
    return r;
  endfunction

  task automatic cycle();
    int g;
    logic [NP-1:0] eg;
    for (int i = 0; i < NP; i++) begin
      req[i] = pend[i]; we[i] = c_we[i];
      addr[i*AW +: AW] = c_addr[i]; w_data[i*DW +: DW] = c_data[i];
    end
    @(negedge clk);
    g = -1;
    if (!m_busy && !init_start)
      for (int k = 1; k <= NP; k++) begin
        int p = (m_rr + k) % NP;
        if (g < 0 && pend[p]) g = p;
      end
    eg = (g >= 0) ? (NP'(1) << g) : '0;
    obs_gnt = gnt;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("init_busy", 32'(init_busy), 32'(m_busy));
    check_eq("r_valid", 32'(r_valid), 32'(m_rv));
    check_eq("r_data", r_data, m_rd);
    if (init_busy) busy_seen++;
    if (g >= 0) gcount[g]++;
    m_rv = '0;
    if (m_busy) begin
      mm[m_cnt] = '0; m_cnt++;
      if (m_cnt == DEPTH) m_busy = 0;
    end else if (init_start) begin
      m_busy = 1; m_cnt = 0;
    end else if (g >= 0) begin
      m_rr = g; pend[g] = 0;
      if (c_we[g]) begin
        if (c_addr[g] < DEPTH) mm[c_addr[g]] = c_data[g];
      end else begin
        m_rv[g] = 1'b1;
        m_rd = (c_addr[g] < DEPTH) ? mm[c_addr[g]] : '0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (any_pend() && n < 500) begin cycle(); n++; end
    check_eq("drain_bound", 32'(any_pend()), 32'd0);
  endtask

  task automatic run_init();
    int n = 0;
    init_start = 1'b1; cycle(); init_start = 1'b0;
    busy_seen = 0;
    while (m_busy && n < 1000) begin cycle(); n++; end
    check_eq("init_len", 32'(busy_seen), 32'(DEPTH));
  endtask

  initial begin
    req = '0; we = '0; addr = '0; w_data = '0; init_start = 1'b0;
    for (int i = 0; i < NP; i++) begin c_we[i] = 0; c_addr[i] = '0; c_data[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_rvalid", 32'(r_valid), 32'd0);
    check_eq("rst_rdata", r_data, 32'd0);
    check_eq("rst_busy", 32'(init_busy), 32'd0);
    rst_n = 1'b1;

    run_init();

    // Single port write then read-back.
    post(0, 1, 5, 32'hDEADBEEF); drain();
    post(0, 0, 5, 32'h0); drain();
    check_eq("sp_rvalid", 32'(r_valid), 32'h1);
    check_eq("sp_rdata", r_data, 32'hDEADBEEF);
    cycle();

    // Full contention: every port reads continuously.
    for (int i = 0; i < NP; i++) gcount[i] = 0;
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < NP; p++) if (!pend[p]) post(p, 0, $urandom_range(0, DEPTH-1), 32'h0);
      cycle();
    end
    for (int p = 0; p < NP; p++) check_eq("rr_share", 32'(gcount[p]), 32'd4);
    drain(); cycle();

    // Fairness skip with only ports 1 and 3 asking.
    post(1, 0, 7, 32'h0); drain();
    post(1, 0, 8, 32'h0); post(3, 0, 9, 32'h0); cycle();
    check_eq("skip_a", 32'(obs_gnt), 32'h8);
    post(3, 0, 10, 32'h0); cycle();
    check_eq("skip_b", 32'(obs_gnt), 32'h2);
    cycle();
    check_eq("skip_c", 32'(obs_gnt), 32'h8);
    drain(); cycle();

    // Fill with nonzero data, then init with all ports requesting.
    for (int a = 0; a < DEPTH; a++) begin post(a % NP, 1, a, 32'hC0DE0000 | a); drain(); end
    post(0, 0, 0, 32'h0); post(1, 0, 128, 32'h0); post(2, 0, DEPTH-1, 32'h0); post(3, 0, 77, 32'h0);
    run_init();
    drain(); cycle();

    // Reset in the middle of an init walk.
    post(2, 1, DEPTH-1, 32'hA5A5A5A5); drain();
    init_start = 1'b1; cycle(); init_start = 1'b0;
    while (m_busy && m_cnt < 100) cycle();
    rst_n = 1'b0; #1;
    check_eq("midrst_busy", 32'(init_busy), 32'd0);
    check_eq("midrst_rvalid", 32'(r_valid), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    post(1, 0, 0, 32'h0); drain();
    check_eq("midrst_addr0", r_data, 32'h0);
    post(0, 0, DEPTH-1, 32'h0); drain();
    check_eq("midrst_keep", r_data, 32'hA5A5A5A5);

    // Out of range access.
    post(2, 1, 210, 32'h1234); drain();
    post(2, 0, 210, 32'h0); drain();
    check_eq("oor_rvalid", 32'(r_valid), 32'h4);
    check_eq("oor_rdata", r_data, 32'h0);
    post(3, 0, DEPTH-1, 32'h0); drain();
    check_eq("oor_keep", r_data, 32'hA5A5A5A5);
    cycle();

    // Randomized traffic with occasional init pulses.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++)
        if (!pend[p] && ($urandom % 3 == 0))
          post(p, bit'($urandom % 2), $urandom_range(0, 255), $urandom);
      init_start = ($urandom % 80 == 0);
      cycle();
      init_start = 1'b0;
    end
    drain(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
